// File: rtl/apb_bfm_pkg.sv
// Shared types and widths for the APB completer model.
package apb_bfm_pkg;

    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_AW = 32;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Request fields captured in the setup cycle and held for the access phase
    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic              write;
    } apb_req_t;

endpackage

// File: rtl/apb_slave_bfm_if.sv
// APB3 bus between a requester and one completer select line.
interface apb_slave_bfm_if;
    import apb_bfm_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_proto_chk.sv
// Protocol monitor: flags illegal requester sequences and keeps a sticky flag.
module apb_slave_proto_chk
    import apb_bfm_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  state_e   state,
    input  logic     pready,
    input  logic     psel,
    input  logic     penable,
    input  apb_req_t req_in,
    input  apb_req_t req_q,
    output logic     viol_c,
    output logic     proto_err
);

    // Current-cycle violation, also used by the FSM to abandon the transfer
    always_comb begin
        viol_c = 1'b0;
        if (state == IDLE) begin
            viol_c = penable;
        end else begin
            viol_c = (!psel && !pready) || !penable || (req_in != req_q);
        end
    end

    // Sticky flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (viol_c) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: rtl/apb_slave_bfm.sv
// APB3 completer model: word memory, programmable wait states, error response
// on misaligned/out-of-range/hook addresses, and a protocol monitor.
module apb_slave_bfm
    import apb_bfm_pkg::*;
#(
    parameter int unsigned       MEM_AW   = 10,
    parameter logic [APB_AW-1:0] ERR_ADDR = 32'hFFFF_FFF0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_slave_bfm_if.slave    apb,
    input  logic [WAIT_W-1:0] WAIT_CFG,
    output logic [CNT_W-1:0]  XFER_CNT,
    output logic              PROTO_ERR
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    state_e              state, state_n;
    apb_req_t            req_q, req_n, req_in_c;
    logic                err_q, err_n, err_in_c;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_n;
    logic                pready_q, pready_n;
    logic                pslverr_q, pslverr_n;
    logic [APB_DW-1:0]   prdata_q, prdata_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                mem_we_c;
    logic                viol_c;
    logic [MEM_AW-1:0]   idx_in_c, idx_q_c;
    logic [APB_DW-1:0]   mem [DEPTH];

    assign req_in_c = '{addr: apb.PADDR, wdata: apb.PWDATA, write: apb.PWRITE};
    assign idx_in_c = apb.PADDR[MEM_AW+1:2];
    assign idx_q_c  = req_q.addr[MEM_AW+1:2];
    assign err_in_c = (apb.PADDR[1:0] != 2'b00)
                    | ((apb.PADDR >> (MEM_AW + 2)) != '0)
                    | (apb.PADDR == ERR_ADDR);

    apb_slave_proto_chk u_proto_chk (
        .clk       (PCLK),
        .rst       (PRESET),
        .state     (state),
        .pready    (pready_q),
        .psel      (apb.PSEL),
        .penable   (apb.PENABLE),
        .req_in    (req_in_c),
        .req_q     (req_q),
        .viol_c    (viol_c),
        .proto_err (PROTO_ERR)
    );

    // Next-state and response logic; PREADY/PSLVERR/PRDATA default to a one-cycle pulse
    always_comb begin
        state_n   = state;
        req_n     = req_q;
        err_n     = err_q;
        wcnt_n    = wcnt_q;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        prdata_n  = '0;
        cnt_n     = cnt_q;
        mem_we_c  = 1'b0;
        case (state)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    req_n   = req_in_c;
                    err_n   = err_in_c;
                    wcnt_n  = WAIT_CFG;
                    state_n = ACCESS;
                    if (WAIT_CFG == '0) begin
                        pready_n  = 1'b1;
                        pslverr_n = err_in_c;
                        prdata_n  = (!apb.PWRITE && !err_in_c) ? mem[idx_in_c] : '0;
                    end
                end
            end
            ACCESS: begin
                if (viol_c) begin
                    state_n = IDLE;
                end else if (pready_q) begin
                    mem_we_c = req_q.write && !err_q;
                    cnt_n    = cnt_q + CNT_W'(1);
                    state_n  = IDLE;
                end else begin
                    wcnt_n = wcnt_q - WAIT_W'(1);
                    if (wcnt_q == WAIT_W'(1)) begin
                        pready_n  = 1'b1;
                        pslverr_n = err_q;
                        prdata_n  = (!req_q.write && !err_q) ? mem[idx_q_c] : '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and response registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            req_q     <= '0;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            req_q     <= req_n;
            err_q     <= err_n;
            wcnt_q    <= wcnt_n;
            pready_q  <= pready_n;
            pslverr_q <= pslverr_n;
            prdata_q  <= prdata_n;
            cnt_q     <= cnt_n;
        end
    end

    // Memory write on completion; contents survive reset, but reset cancels the write
    always_ff @(posedge PCLK) begin
        if (mem_we_c && !PRESET) begin
            mem[idx_q_c] <= req_q.wdata;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
    assign XFER_CNT    = cnt_q;

endmodule

// File: tb/tb_apb_slave_bfm.sv
// Directed bench for the APB completer model.
module tb_apb_slave_bfm;
    import apb_bfm_pkg::*;

    localparam logic [31:0] ERR_ADDR = 32'hFFFF_FFF0;

    logic        clk;
    logic        rst;
    logic [3:0]  wait_cfg;
    logic [15:0] xfer_cnt;
    logic        proto_err;
    int          checks;
    int          errors;

    apb_slave_bfm_if apb ();

    apb_slave_bfm #(
        .MEM_AW   (10),
        .ERR_ADDR (ERR_ADDR),
        .CNT_W    (16)
    ) dut (
        .PCLK      (clk),
        .PRESET    (rst),
        .apb       (apb.slave),
        .WAIT_CFG  (wait_cfg),
        .XFER_CNT  (xfer_cnt),
        .PROTO_ERR (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst         = 1'b1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One transfer: setup, access until PREADY, checks wait count and response
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wcfg,
                        input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(posedge clk); #1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        wait_cfg    = wcfg;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        wait_cfg    = 4'hF;
        n = 0;
        while (!apb.PREADY && n < 40) begin
            check({tag, "_wait_prdata"}, apb.PRDATA, 32'h0);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_waits"}, 32'(n), 32'(wcfg));
        check({tag, "_pslverr"}, 32'(apb.PSLVERR), 32'(exp_err));
        if (!wr) check({tag, "_prdata"}, apb.PRDATA, exp_rd);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        wait_cfg    = 4'h0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 32'h0;
        apb.PWDATA  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pready", 32'(apb.PREADY), 32'h0);
        check("rst_pslverr", 32'(apb.PSLVERR), 32'h0);
        check("rst_prdata", apb.PRDATA, 32'h0);
        check("rst_cnt", 32'(xfer_cnt), 32'h0);
        check("rst_proto", 32'(proto_err), 32'h0);
        rst = 1'b0;

        // Zero wait states: write then read back
        xfer("t1_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'd0, 32'h0, 1'b0);
        xfer("t1_rd", 1'b0, 32'h10, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
        idle_cycle();
        check("t1_cnt", 32'(xfer_cnt), 32'd2);

        // Three wait states on a read; WAIT_CFG changes mid-transfer are ignored
        xfer("t2_wr", 1'b1, 32'h20, 32'h1234_5678, 4'd0, 32'h0, 1'b0);
        xfer("t2_rd", 1'b0, 32'h20, 32'h0, 4'd3, 32'h1234_5678, 1'b0);
        idle_cycle();
        check("t2_cnt", 32'(xfer_cnt), 32'd4);
        idle_cycle();
        check("t2_pready_after", 32'(apb.PREADY), 32'h0);
        check("t2_cnt_once", 32'(xfer_cnt), 32'd4);

        // Back-to-back transfers with no idle cycles
        do_reset();
        check("t4_cnt_rst", 32'(xfer_cnt), 32'd0);
        xfer("t4_wr0", 1'b1, 32'h0, 32'h1111_0000, 4'd0, 32'h0, 1'b0);
        xfer("t4_wr4", 1'b1, 32'h4, 32'h2222_0004, 4'd1, 32'h0, 1'b0);
        xfer("t4_wr8", 1'b1, 32'h8, 32'h3333_0008, 4'd0, 32'h0, 1'b0);
        xfer("t4_rd0", 1'b0, 32'h0, 32'h0, 4'd0, 32'h1111_0000, 1'b0);
        xfer("t4_rd4", 1'b0, 32'h4, 32'h0, 4'd2, 32'h2222_0004, 1'b0);
        xfer("t4_rd8", 1'b0, 32'h8, 32'h0, 4'd0, 32'h3333_0008, 1'b0);
        idle_cycle();
        check("t4_cnt", 32'(xfer_cnt), 32'd6);

        // Error responses: misaligned write is dropped, hook address reads 0
        do_reset();
        xfer("t3_wr_mis", 1'b1, 32'h2, 32'h5, 4'd0, 32'h0, 1'b1);
        xfer("t3_rd_err", 1'b0, ERR_ADDR, 32'h0, 4'd1, 32'h0, 1'b1);
        idle_cycle();
        check("t3_cnt", 32'(xfer_cnt), 32'd2);
        xfer("t3_rd_oor", 1'b0, 32'h0000_1000, 32'h0, 4'd0, 32'h0, 1'b1);
        xfer("t3_rd0", 1'b0, 32'h0, 32'h0, 4'd0, 32'h1111_0000, 1'b0);
        idle_cycle();
        check("t3_cnt2", 32'(xfer_cnt), 32'd4);

        // Reset during a wait state abandons the write
        xfer("t5_wr_old", 1'b1, 32'h30, 32'hA5A5_0030, 4'd0, 32'h0, 1'b0);
        @(posedge clk); #1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = 32'h30;
        apb.PWDATA  = 32'h5A5A_FFFF;
        wait_cfg    = 4'd3;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_pready", 32'(apb.PREADY), 32'h0);
        check("t5_cnt", 32'(xfer_cnt), 32'd0);
        rst         = 1'b0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        xfer("t5_rd", 1'b0, 32'h30, 32'h0, 4'd0, 32'hA5A5_0030, 1'b0);
        idle_cycle();
        check("t5_cnt_after", 32'(xfer_cnt), 32'd1);

        // Protocol violations: PENABLE without setup, then PADDR change mid-access
        check("t6_proto_clear", 32'(proto_err), 32'h0);
        @(posedge clk); #1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = 32'h40;
        @(posedge clk); #1;
        check("t6_proto_noset", 32'(proto_err), 32'h1);
        check("t6_pready_noset", 32'(apb.PREADY), 32'h0);
        apb.PENABLE = 1'b0;
        wait_cfg    = 4'd2;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        apb.PADDR   = 32'h44;
        @(posedge clk); #1;
        check("t6_pready_abort", 32'(apb.PREADY), 32'h0);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        check("t6_cnt_abort", 32'(xfer_cnt), 32'd1);
        xfer("t6_rd", 1'b0, 32'h30, 32'h0, 4'd0, 32'hA5A5_0030, 1'b0);
        idle_cycle();
        check("t6_cnt", 32'(xfer_cnt), 32'd2);
        check("t6_proto_sticky", 32'(proto_err), 32'h1);
        do_reset();
        check("t6_proto_rst", 32'(proto_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
